// File: rtl/pipe_pkg.sv
// Shared types and control-bundle field positions for the valid/ready pipeline stage registers.
// A control bundle of all zeros is a NOP: no write enable, no memory access, no redirect.
package pipe_pkg;

  typedef enum logic [1:0] {
    PS_EMPTY = 2'd0,
    PS_ONE   = 2'd1,
    PS_TWO   = 2'd2
  } pipe_state_t;

  localparam int DATA_W_DEFAULT = 96;
  localparam int CTRL_W_DEFAULT = 16;

  // Bit positions inside the standard 16-bit stage control bundle
  localparam int CTRL_REG_WRITE  = 0;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_READ   = 2;
  localparam int CTRL_BRANCH     = 3;
  localparam int CTRL_JUMP       = 4;
  localparam int CTRL_ALU_LSB    = 5;
  localparam int CTRL_ALU_MSB    = 8;
  localparam int CTRL_RES_LSB    = 9;
  localparam int CTRL_RES_MSB    = 10;
  localparam int CTRL_ALU_SRC    = 11;
  localparam int CTRL_VEC        = 12;
  localparam int CTRL_EXC        = 13;

  localparam logic [CTRL_W_DEFAULT-1:0] NOP_CTRL = '0;

  function automatic logic [1:0] occ_of(input pipe_state_t st);
    case (st)
      PS_ONE:  return 2'd1;
      PS_TWO:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One held pipeline entry: valid flag plus control and data payload.
// Clear has priority over load and always zeroes the payload, so an invalid entry never carries data.
module pipe_entry #(
  parameter int CTRL_W = 16,
  parameter int DATA_W = 96
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              clear,
  input  logic [CTRL_W-1:0] load_ctrl,
  input  logic [DATA_W-1:0] load_data,
  output logic              valid,
  output logic [CTRL_W-1:0] ctrl,
  output logic [DATA_W-1:0] data
);

  logic              valid_reg;
  logic [CTRL_W-1:0] ctrl_reg;
  logic [DATA_W-1:0] data_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      data_reg  <= '0;
    end else if (clear) begin
      valid_reg <= 1'b0;
      ctrl_reg  <= '0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= 1'b1;
      ctrl_reg  <= load_ctrl;
      data_reg  <= load_data;
    end
  end

  assign valid = valid_reg;
  assign ctrl  = ctrl_reg;
  assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_hs.sv
// Inter-stage pipeline register with valid/ready handshake, synchronous flush and an optional
// second (skid) entry that lets in_ready be registered instead of combinational from out_ready.
module pipe_stage_hs #(
  parameter int DATA_W = 96,
  parameter int CTRL_W = 16,
  parameter int SKID   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        occupancy
);

  import pipe_pkg::*;

  pipe_state_t state_reg, state_next;

  logic              in_xfer, out_xfer;
  logic              main_load, main_clear, main_from_skid;
  logic              skid_load, skid_clear;
  logic              main_valid, skid_valid;
  logic [CTRL_W-1:0] main_ctrl, skid_ctrl, main_in_ctrl;
  logic [DATA_W-1:0] main_data, skid_data, main_in_data;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = main_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= PS_EMPTY;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    main_load      = 1'b0;
    main_clear     = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (flush) begin
      // Flush beats any concurrent transfer: the accepted input is simply discarded
      state_next = PS_EMPTY;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      case (state_reg)
        PS_EMPTY: begin
          if (in_xfer) begin
            state_next = PS_ONE;
            main_load  = 1'b1;
          end
        end
        PS_ONE: begin
          if (in_xfer && out_xfer) begin
            main_load = 1'b1;
          end else if (in_xfer) begin
            if (SKID != 0) begin
              state_next = PS_TWO;
              skid_load  = 1'b1;
            end
          end else if (out_xfer) begin
            state_next = PS_EMPTY;
            main_clear = 1'b1;
          end
        end
        PS_TWO: begin
          // in_ready is low here, so only the head can move
          if (out_xfer) begin
            state_next     = PS_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_next = PS_EMPTY;
          main_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign main_in_ctrl = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_in_data = main_from_skid ? skid_data : in_data;

  pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_main (
    .clk       (clk),
    .reset     (reset),
    .load      (main_load),
    .clear     (main_clear),
    .load_ctrl (main_in_ctrl),
    .load_data (main_in_data),
    .valid     (main_valid),
    .ctrl      (main_ctrl),
    .data      (main_data)
  );

  generate
    if (SKID != 0) begin : g_skid
      logic in_ready_reg;

      pipe_entry #(.CTRL_W(CTRL_W), .DATA_W(DATA_W)) u_skid (
        .clk       (clk),
        .reset     (reset),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_ctrl (in_ctrl),
        .load_data (in_data),
        .valid     (skid_valid),
        .ctrl      (skid_ctrl),
        .data      (skid_data)
      );

      // Registered ready: no combinational path from out_ready back upstream
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          in_ready_reg <= 1'b1;
        end else begin
          in_ready_reg <= (state_next != PS_TWO);
        end
      end

      assign in_ready = in_ready_reg;
    end else begin : g_noskid
      assign skid_valid = 1'b0;
      assign skid_ctrl  = '0;
      assign skid_data  = '0;
      assign in_ready   = !main_valid || out_ready;
    end
  endgenerate

  assign out_valid = main_valid;
  assign out_ctrl  = main_valid ? main_ctrl : '0;
  assign out_data  = main_valid ? main_data : '0;
  assign occupancy = occ_of(state_reg);

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Directed bench for pipe_stage_hs: a SKID=1 instance for most scenarios and a SKID=0 instance
// for the combinational-ready behaviour. Observed vector = {valid, occupancy, in_ready, ctrl, data}.
module tb_pipe_stage_hs;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_ctrl;
  logic [95:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_ctrl;
  logic [95:0] out_data;
  logic [1:0]  occupancy;

  logic        s0_flush;
  logic        s0_in_valid;
  logic        s0_in_ready;
  logic [15:0] s0_in_ctrl;
  logic [95:0] s0_in_data;
  logic        s0_out_valid;
  logic        s0_out_ready;
  logic [15:0] s0_out_ctrl;
  logic [95:0] s0_out_data;
  logic [1:0]  s0_occupancy;

  logic [115:0] obs, obs0, exp;
  int checks = 0;
  int errors = 0;

  pipe_stage_hs #(.DATA_W(96), .CTRL_W(16), .SKID(1)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ctrl   (in_ctrl),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ctrl  (out_ctrl),
    .out_data  (out_data),
    .occupancy (occupancy)
  );

  pipe_stage_hs #(.DATA_W(96), .CTRL_W(16), .SKID(0)) u_dut0 (
    .clk       (clk),
    .reset     (reset),
    .flush     (s0_flush),
    .in_valid  (s0_in_valid),
    .in_ready  (s0_in_ready),
    .in_ctrl   (s0_in_ctrl),
    .in_data   (s0_in_data),
    .out_valid (s0_out_valid),
    .out_ready (s0_out_ready),
    .out_ctrl  (s0_out_ctrl),
    .out_data  (s0_out_data),
    .occupancy (s0_occupancy)
  );

  assign obs  = {out_valid, occupancy, in_ready, out_ctrl, out_data};
  assign obs0 = {s0_out_valid, s0_occupancy, s0_in_ready, s0_out_ctrl, s0_out_data};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pc(input int k);
    return {8'hC0, 8'(k)};
  endfunction

  function automatic logic [95:0] pd(input int k);
    return {32'hDA7A_0000 | 32'(k), 32'(k) * 32'd3 + 32'd1, ~32'(k)};
  endfunction

  function automatic logic [115:0] ex(input logic v, input logic [1:0] occ, input logic rdy,
                                     input logic [15:0] c, input logic [95:0] d);
    return {v, occ, rdy, c, d};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic v, input int k);
    in_valid = v;
    in_ctrl  = v ? pc(k) : 16'h0;
    in_data  = v ? pd(k) : 96'h0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp = ex(1'b0, 2'd0, 1'b1, 16'h0, 96'h0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_held: got %h expected %h", obs, exp); end
    reset = 1'b1;
    tick();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL reset_released: got %h expected %h", obs, exp); end
    $display("reset: obs=%h", obs);
  endtask

  task automatic test_stream();
    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      push(1'b1, k);
      tick();
      exp = ex(1'b1, 2'd1, 1'b1, pc(k), pd(k));
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL stream_%0d: got %h expected %h", k, obs, exp); end
      $display("stream %0d: out_ctrl=%h", k, out_ctrl);
    end
    push(1'b0, 0);
    tick();
    exp = ex(1'b0, 2'd0, 1'b1, 16'h0, 96'h0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL stream_drain: got %h expected %h", obs, exp); end
  endtask

  task automatic test_stall_fill();
    out_ready = 1'b0;
    push(1'b1, 8'h11);
    tick();
    exp = ex(1'b1, 2'd1, 1'b1, pc(8'h11), pd(8'h11));
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL stall_one: got %h expected %h", obs, exp); end
    push(1'b1, 8'h12);
    tick();
    exp = ex(1'b1, 2'd2, 1'b0, pc(8'h11), pd(8'h11));
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL stall_two: got %h expected %h", obs, exp); end
    push(1'b1, 8'h13);
    tick();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL stall_hold: got %h expected %h", obs, exp); end
    push(1'b0, 0);
    out_ready = 1'b1;
    #1;
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL stall_release_a: got %h expected %h", obs, exp); end
    tick();
    exp = ex(1'b1, 2'd1, 1'b1, pc(8'h12), pd(8'h12));
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL stall_release_b: got %h expected %h", obs, exp); end
    tick();
    exp = ex(1'b0, 2'd0, 1'b1, 16'h0, 96'h0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL stall_empty: got %h expected %h", obs, exp); end
    $display("stall_fill: final obs=%h", obs);
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    push(1'b1, 8'h21);
    tick();
    push(1'b1, 8'h22);
    tick();
    exp = ex(1'b1, 2'd2, 1'b0, pc(8'h21), pd(8'h21));
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL flush_fill: got %h expected %h", obs, exp); end
    push(1'b1, 8'h23);
    flush = 1'b1;
    tick();
    exp = ex(1'b0, 2'd0, 1'b1, 16'h0, 96'h0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL flush_two: got %h expected %h", obs, exp); end
    flush = 1'b0;
    push(1'b0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++;
      if (obs !== exp) begin errors++; $display("FAIL flush_no_c_%0d: got %h expected %h", i, obs, exp); end
    end
    out_ready = 1'b0;
    push(1'b1, 8'h24);
    tick();
    push(1'b1, 8'h25);
    flush = 1'b1;
    tick();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL flush_one_push: got %h expected %h", obs, exp); end
    flush = 1'b0;
    push(1'b0, 0);
    out_ready = 1'b1;
    tick();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL flush_after: got %h expected %h", obs, exp); end
    $display("flush: final obs=%h", obs);
  endtask

  task automatic test_bubble();
    out_ready = 1'b1;
    push(1'b1, 8'h31);
    tick();
    exp = ex(1'b1, 2'd1, 1'b1, pc(8'h31), pd(8'h31));
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL bubble_x: got %h expected %h", obs, exp); end
    push(1'b0, 0);
    tick();
    exp = ex(1'b0, 2'd0, 1'b1, 16'h0, 96'h0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL bubble_gap: got %h expected %h", obs, exp); end
    push(1'b1, 8'h32);
    tick();
    exp = ex(1'b1, 2'd1, 1'b1, pc(8'h32), pd(8'h32));
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL bubble_y: got %h expected %h", obs, exp); end
    push(1'b0, 0);
    tick();
    $display("bubble: final obs=%h", obs);
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    push(1'b1, 8'h51);
    tick();
    push(1'b1, 8'h52);
    tick();
    exp = ex(1'b1, 2'd2, 1'b0, pc(8'h51), pd(8'h51));
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rstmid_fill: got %h expected %h", obs, exp); end
    push(1'b0, 0);
    reset = 1'b0;
    #1;
    exp = ex(1'b0, 2'd0, 1'b1, 16'h0, 96'h0);
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rstmid_async: got %h expected %h", obs, exp); end
    tick();
    reset = 1'b1;
    tick();
    checks++;
    if (obs !== exp) begin errors++; $display("FAIL rstmid_after: got %h expected %h", obs, exp); end
    $display("reset_mid: obs=%h", obs);
  endtask

  task automatic test_noskid();
    s0_out_ready = 1'b0;
    s0_in_valid  = 1'b1;
    s0_in_ctrl   = pc(8'h41);
    s0_in_data   = pd(8'h41);
    #1;
    exp = ex(1'b0, 2'd0, 1'b1, 16'h0, 96'h0);
    checks++;
    if (obs0 !== exp) begin errors++; $display("FAIL s0_empty_ready: got %h expected %h", obs0, exp); end
    tick();
    s0_in_ctrl = pc(8'h42);
    s0_in_data = pd(8'h42);
    #1;
    exp = ex(1'b1, 2'd1, 1'b0, pc(8'h41), pd(8'h41));
    checks++;
    if (obs0 !== exp) begin errors++; $display("FAIL s0_stall_ready: got %h expected %h", obs0, exp); end
    s0_out_ready = 1'b1;
    #1;
    exp = ex(1'b1, 2'd1, 1'b1, pc(8'h41), pd(8'h41));
    checks++;
    if (obs0 !== exp) begin errors++; $display("FAIL s0_comb_ready: got %h expected %h", obs0, exp); end
    tick();
    exp = ex(1'b1, 2'd1, 1'b1, pc(8'h42), pd(8'h42));
    checks++;
    if (obs0 !== exp) begin errors++; $display("FAIL s0_replace: got %h expected %h", obs0, exp); end
    s0_out_ready = 1'b0;
    #1;
    exp = ex(1'b1, 2'd1, 1'b0, pc(8'h42), pd(8'h42));
    checks++;
    if (obs0 !== exp) begin errors++; $display("FAIL s0_stall_again: got %h expected %h", obs0, exp); end
    s0_in_valid  = 1'b0;
    s0_out_ready = 1'b1;
    tick();
    exp = ex(1'b0, 2'd0, 1'b1, 16'h0, 96'h0);
    checks++;
    if (obs0 !== exp) begin errors++; $display("FAIL s0_drain: got %h expected %h", obs0, exp); end
    $display("noskid: final obs0=%h", obs0);
  endtask

  initial begin
    flush        = 1'b0;
    in_valid     = 1'b0;
    in_ctrl      = '0;
    in_data      = '0;
    out_ready    = 1'b0;
    s0_flush     = 1'b0;
    s0_in_valid  = 1'b0;
    s0_in_ctrl   = '0;
    s0_in_data   = '0;
    s0_out_ready = 1'b0;
    test_reset();
    test_stream();
    test_stall_fill();
    test_flush();
    test_bubble();
    test_reset_mid();
    test_noskid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
